// File: rtl/gpio_pkg.sv
// Shared GPIO defaults: counter and prescaler widths used across the GPIO blocks.
package gpio_pkg;
  localparam int GPIO_CNT_W   = 16;
  localparam int GPIO_PRESC_W = 16;
endpackage

// File: rtl/gpio_debounce_ch.sv
// Single-channel debounce: tick-driven mismatch counter, filtered level flop and
// combinational edge strobes that line up with the filtered-level update.
module gpio_debounce_ch
  import gpio_pkg::*;
#(
  parameter int CNT_W = GPIO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             di_i,
  input  logic [CNT_W-1:0] db_limit_i,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so the increment can never wrap before the compare.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (db_limit_i == '0) begin
      cnt_d  = '0;
      filt_d = di_i;
    end else if (di_i == filt_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_inc >= {1'b0, db_limit_i}) begin
        filt_d = di_i;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_d & ~filt_q;
  assign fall_o = ~filt_d & filt_q;

endmodule

// File: rtl/gpio_debounce_irq.sv
// Per-channel debounce with edge capture, sticky W1C pending bits and a
// registered level interrupt toward the register/CPU block.
module gpio_debounce_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = GPIO_CNT_W,
  parameter int PRESC_W = GPIO_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   di_sync,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   db_limit,
  input  logic [WIDTH-1:0]   rise_en,
  input  logic [WIDTH-1:0]   fall_en,
  input  logic [WIDTH-1:0]   irq_en,
  input  logic               clr_valid,
  input  logic [WIDTH-1:0]   clr_mask,
  output logic [WIDTH-1:0]   di_filt,
  output logic [WIDTH-1:0]   irq_pend,
  output logic               irq
);

  logic [PRESC_W-1:0] pc_q, pc_d;
  logic               tick;
  logic [WIDTH-1:0]   rise, fall, clr;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               irq_q, irq_d;

  // >= rather than == so a shrinking presc takes effect without a full wrap.
  assign tick = (pc_q >= presc);
  assign pc_d = tick ? '0 : pc_q + {{(PRESC_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gpio_debounce_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick),
      .di_i       (di_sync[i]),
      .db_limit_i (db_limit),
      .filt_o     (di_filt[i]),
      .rise_o     (rise[i]),
      .fall_o     (fall[i])
    );
  end

  // Set terms are OR-ed after the clear so a same-cycle edge wins.
  assign clr    = clr_valid ? clr_mask : '0;
  assign pend_d = (pend_q & ~clr) | (rise & rise_en) | (fall & fall_en);
  assign irq_d  = |(pend_q & irq_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_pend = pend_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Bench for gpio_debounce_irq: directed corner sequences, a bypass vector table
// and a randomized phase, all checked against a behavioural model.
module tb_gpio_debounce_irq;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  di_sync;
  logic [15:0]       presc;
  logic [15:0]       db_limit;
  logic [WIDTH-1:0]  rise_en, fall_en, irq_en, clr_mask;
  logic              clr_valid;
  logic [WIDTH-1:0]  di_filt, irq_pend;
  logic              irq;

  gpio_debounce_irq #(.WIDTH(WIDTH), .CNT_W(16), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .di_sync(di_sync), .presc(presc), .db_limit(db_limit),
    .rise_en(rise_en), .fall_en(fall_en), .irq_en(irq_en),
    .clr_valid(clr_valid), .clr_mask(clr_mask),
    .di_filt(di_filt), .irq_pend(irq_pend), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: time-since-mismatch in ticks per channel, accepted once it reaches the limit.
  int               m_pc;
  int               m_ticks [WIDTH];
  logic [WIDTH-1:0] m_filt, m_pend;
  logic             m_irq;

  typedef struct {
    logic [WIDTH-1:0] di;
    logic [WIDTH-1:0] exp_filt;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [WIDTH-1:0] nf, rise, fall, clr;
    bit tick;
    if (rst) begin
      m_pc = 0; m_filt = '0; m_pend = '0; m_irq = 1'b0;
      for (int i = 0; i < WIDTH; i++) m_ticks[i] = 0;
      return;
    end
    tick = (m_pc >= int'(presc));
    nf = m_filt;
    for (int i = 0; i < WIDTH; i++) begin
      if (db_limit == 0) begin
        nf[i] = di_sync[i];
        m_ticks[i] = 0;
      end else if (di_sync[i] == m_filt[i]) begin
        m_ticks[i] = 0;
      end else if (tick) begin
        m_ticks[i] = m_ticks[i] + 1;
        if (m_ticks[i] >= int'(db_limit)) begin
          nf[i] = di_sync[i];
          m_ticks[i] = 0;
        end
      end
    end
    rise   = nf & ~m_filt;
    fall   = ~nf & m_filt;
    clr    = clr_valid ? clr_mask : '0;
    m_irq  = |(m_pend & irq_en);
    m_pend = (m_pend & ~clr) | (rise & rise_en) | (fall & fall_en);
    m_filt = nf;
    m_pc   = tick ? 0 : m_pc + 1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("model_filt", di_filt, m_filt);
    chk("model_pend", irq_pend, m_pend);
    chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    tbl[0] = '{32'hFFFF_0000, 32'hFFFF_0000};
    tbl[1] = '{32'h1234_5678, 32'h1234_5678};
    tbl[2] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[3] = '{32'h0F0F_F0F0, 32'h0F0F_F0F0};
    tbl[4] = '{32'hAAAA_5555, 32'hAAAA_5555};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000};

    // Reset with all inputs high
    rst = 1'b1; di_sync = '1; presc = 16'd0; db_limit = 16'd4;
    rise_en = 32'hA5A5_0F0F; fall_en = '1; irq_en = '0;
    clr_valid = 1'b0; clr_mask = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_filt", di_filt, '0);
      chk("rst_pend", irq_pend, '0);
      chk("rst_irq", {31'b0, irq}, '0);
    end
    rst = 1'b0;
    steps(3);
    chk("post_rst_filt3", di_filt, '0);
    step();
    chk("post_rst_filt4", di_filt, '1);
    chk("post_rst_pend", irq_pend, 32'hA5A5_0F0F);
    clr_valid = 1'b1; clr_mask = '1; step(); clr_valid = 1'b0;
    chk("clr_all", irq_pend, '0);

    // Bounce rejection on ch0
    db_limit = 16'd5; di_sync = '0; steps(5);
    chk("fall_all", di_filt, '0);
    clr_valid = 1'b1; step(); clr_valid = 1'b0;
    di_sync[0] = 1'b1; steps(3);
    di_sync[0] = 1'b0; step();
    di_sync[0] = 1'b1; steps(4);
    chk("bounce_pre", di_filt, '0);
    step();
    chk("bounce_acc", di_filt, 32'h1);
    chk("bounce_pend", irq_pend, 32'h1);

    // Prescaler: third tick on ch7
    presc = 16'd9; db_limit = 16'd3; di_sync[7] = 1'b1;
    steps(29);
    chk("presc_pre", di_filt, 32'h1);
    step();
    chk("presc_acc", di_filt, 32'h81);
    chk("presc_no_rise", irq_pend, 32'h1);

    // Edge enables on ch3
    presc = 16'd0; db_limit = 16'd2; irq_en = 32'h8; rise_en = 32'hA5A5_0F07;
    clr_valid = 1'b1; clr_mask = '1; step(); clr_valid = 1'b0;
    di_sync[3] = 1'b1; steps(2);
    chk("ch3_hi_filt", di_filt, 32'h89);
    chk("ch3_no_rise", irq_pend, '0);
    di_sync[3] = 1'b0; steps(2);
    chk("ch3_fall_pend", irq_pend, 32'h8);
    chk("ch3_irq_lag", {31'b0, irq}, '0);
    step();
    chk("ch3_irq_set", {31'b0, irq}, 32'h1);
    clr_valid = 1'b1; clr_mask = 32'h8; step(); clr_valid = 1'b0;
    chk("ch3_clr_pend", irq_pend, '0);
    chk("ch3_irq_hold", {31'b0, irq}, 32'h1);
    step();
    chk("ch3_irq_drop", {31'b0, irq}, '0);
    irq_en = '0;
    di_sync[3] = 1'b1; steps(2); di_sync[3] = 1'b0; steps(2);
    chk("ch3_masked_pend", irq_pend, 32'h8);
    steps(2);
    chk("ch3_masked_irq", {31'b0, irq}, '0);

    // W1C collision: set wins
    irq_en = 32'h8; step();
    chk("coll_irq_pre", {31'b0, irq}, 32'h1);
    di_sync[3] = 1'b1; steps(2); di_sync[3] = 1'b0; step();
    clr_valid = 1'b1; clr_mask = 32'h8; step();
    chk("coll_set_wins", irq_pend, 32'h8);
    step(); clr_valid = 1'b0;
    chk("coll_clr", irq_pend, '0);
    chk("coll_irq_hold", {31'b0, irq}, 32'h1);
    step();
    chk("coll_irq_drop", {31'b0, irq}, '0);

    // Bypass table
    db_limit = 16'd0; irq_en = '0;
    for (int i = 0; i < 6; i++) begin
      di_sync = tbl[i].di;
      step();
      chk("bypass", di_filt, tbl[i].exp_filt);
    end

    // Lowering the limit mid-count
    db_limit = 16'd100; di_sync = 32'h20; steps(10);
    chk("lim_pre", di_filt, '0);
    db_limit = 16'd2; step();
    chk("lim_acc", di_filt, 32'h20);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        presc    = 16'($urandom_range(0, 3));
        db_limit = 16'($urandom_range(0, 6));
        rise_en  = $urandom; fall_en = $urandom; irq_en = $urandom;
      end
      di_sync   = di_sync ^ ($urandom & $urandom & $urandom);
      clr_valid = ($urandom_range(0, 7) == 0);
      clr_mask  = $urandom;
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
